// File: rtl/button_debouncer_bank.sv
// N-channel push-button debouncer: two-flop synchroniser, per-channel stability
// counter, debounced level plus press / release / long-press strobes.
module button_debouncer_bank #(
    parameter int N_CH         = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CNT = 65535,
    parameter int LONG_CNT     = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] buttons_raw,
    output logic [N_CH-1:0] button_state,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CNT);
    localparam logic [N_CH-1:0] POL_MASK = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

    logic [N_CH-1:0]  sync0_q, sync0_d;
    logic [N_CH-1:0]  sync1_q, sync1_d;
    logic [N_CH-1:0]  state_q, state_d;
    logic [N_CH-1:0]  press_q, press_d;
    logic [N_CH-1:0]  release_q, release_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    // Polarity is folded in before the first flop so every later stage sees 1 = pressed.
    always_comb begin
        sync0_d = buttons_raw ^ POL_MASK;
        sync1_d = sync0_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
        end
    end

    // A disagreement must persist for DEBOUNCE_CNT+1 consecutive edges before the level flips;
    // any agreement in between drops the count back to zero.
    always_comb begin
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (sync1_q[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_TERM) begin
                    state_d[i]   = ~state_q[i];
                    press_d[i]   = ~state_q[i];
                    release_d[i] = state_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign button_state  = state_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

    generate
        if (LONG_CNT > 0) begin : g_long
            localparam int               HOLD_W    = $clog2(LONG_CNT + 1);
            localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(LONG_CNT);
            localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);

            logic [HOLD_W-1:0] hold_q [N_CH];
            logic [HOLD_W-1:0] hold_d [N_CH];
            logic [N_CH-1:0]   long_q, long_d;

            // Hold counter saturates at LONG_CNT, so a single press yields at most one strobe.
            always_comb begin
                long_d = '0;
                for (int i = 0; i < N_CH; i++) begin
                    hold_d[i] = '0;
                    if (state_q[i]) begin
                        if (hold_q[i] < HOLD_TERM) begin
                            hold_d[i] = hold_q[i] + 1'b1;
                            long_d[i] = (hold_q[i] == HOLD_LAST);
                        end else begin
                            hold_d[i] = hold_q[i];
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    long_q <= '0;
                    for (int i = 0; i < N_CH; i++) begin
                        hold_q[i] <= '0;
                    end
                end else begin
                    long_q <= long_d;
                    for (int i = 0; i < N_CH; i++) begin
                        hold_q[i] <= hold_d[i];
                    end
                end
            end

            assign long_pulse = long_q;
        end else begin : g_no_long
            assign long_pulse = '0;
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer_bank.sv
// Bench for button_debouncer_bank: directed timing checks plus randomized
// stimulus against a sliding-window reference model.
module tb_button_debouncer_bank;

    localparam int N_CH = 4;
    localparam int DB   = 3;
    localparam int LONG = 10;

    logic       clk;
    logic       rst_n;
    logic [3:0] buttons_raw;
    logic [3:0] button_state, press_pulse, release_pulse, long_pulse;

    int checks   = 0;
    int failures = 0;

    button_debouncer_bank #(
        .N_CH(N_CH), .ACTIVE_LOW(1), .DEBOUNCE_CNT(DB), .LONG_CNT(LONG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .buttons_raw(buttons_raw),
        .button_state(button_state), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .long_pulse(long_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: pressed samples per edge since reset; the level flips when the
    // synchronised value (sample two edges back) differed from it for DB+1 edges in a row.
    bit smp [4][$];
    bit m_st [4];
    bit m_pr [4];
    bit m_rl [4];
    bit m_lg [4];
    int m_pe [4];
    int ecnt;

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++) begin
            smp[c].delete();
            m_st[c] = 0; m_pr[c] = 0; m_rl[c] = 0; m_lg[c] = 0;
            m_pe[c] = -100000;
        end
        ecnt = 0;
    endfunction

    function automatic bit sync1_at(int c, int w);
        int idx;
        idx = w - 2;
        if (idx < 0) return 1'b0;
        return smp[c][idx];
    endfunction

    function automatic void model_edge(logic [3:0] raw);
        for (int c = 0; c < N_CH; c++) begin
            bit pre;
            bit tog;
            smp[c].push_back(~raw[c]);
            pre = m_st[c];
            tog = 1'b1;
            for (int w = ecnt - DB; w <= ecnt; w++)
                if (sync1_at(c, w) == pre) tog = 1'b0;
            m_pr[c] = 0;
            m_rl[c] = 0;
            m_lg[c] = pre && ((ecnt - m_pe[c]) == LONG);
            if (tog) begin
                m_st[c] = ~pre;
                if (!pre) begin
                    m_pr[c] = 1;
                    m_pe[c] = ecnt;
                end else begin
                    m_rl[c] = 1;
                end
            end
        end
        ecnt++;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_model();
        logic [3:0] es, ep, er, el;
        for (int c = 0; c < N_CH; c++) begin
            es[c] = m_st[c]; ep[c] = m_pr[c]; er[c] = m_rl[c]; el[c] = m_lg[c];
        end
        chk("model_state",   int'(button_state),  int'(es));
        chk("model_press",   int'(press_pulse),   int'(ep));
        chk("model_release", int'(release_pulse), int'(er));
        chk("model_long",    int'(long_pulse),    int'(el));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(buttons_raw);
        #1;
        compare_model();
    endtask

    task automatic async_reset_check(input string name);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk(name, int'({button_state, press_pulse, release_pulse, long_pulse}), 0);
    endtask

    typedef struct {
        logic [3:0] raw;
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int pe, pcnt, rcnt, le, lcnt, pe0, pe3, other, rate;

        // Clean press/release on ch0: low for 8 edges, press at edge 5, release at edge 13.
        for (int i = 0; i < 16; i++) begin
            tbl[i].raw = (i < 8) ? 4'b1110 : 4'b1111;
            tbl[i].st  = (i >= 5 && i < 13) ? 4'b0001 : 4'b0000;
            tbl[i].pr  = (i == 5) ? 4'b0001 : 4'b0000;
            tbl[i].rl  = (i == 13) ? 4'b0001 : 4'b0000;
        end

        rst_n = 1'b0;
        buttons_raw = 4'b1111;
        model_reset();
        #1;
        chk("reset_state", int'(button_state), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // Reset values: press all, then assert reset asynchronously between edges.
        buttons_raw = 4'b0000;
        repeat (8) tick();
        chk("pre_reset_state", int'(button_state), 15);
        buttons_raw = 4'b1111;
        async_reset_check("async_reset_outputs");
        repeat (2) tick();
        rst_n = 1'b1;
        other = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            other += $countones(button_state | press_pulse | release_pulse | long_pulse);
        end
        chk("post_reset_activity", other, 0);

        for (int i = 0; i < 16; i++) begin
            buttons_raw = tbl[i].raw;
            tick();
            chk($sformatf("tbl_state_%0d", i),   int'(button_state),  int'(tbl[i].st));
            chk($sformatf("tbl_press_%0d", i),   int'(press_pulse),   int'(tbl[i].pr));
            chk($sformatf("tbl_release_%0d", i), int'(release_pulse), int'(tbl[i].rl));
            chk($sformatf("tbl_long_%0d", i),    int'(long_pulse),    0);
        end

        // Bounce on ch1: 2-cycle alternation for 20 edges, then held low.
        pe = -1; pcnt = 0; rcnt = 0;
        for (int i = 0; i < 28; i++) begin
            buttons_raw = 4'b1111;
            buttons_raw[1] = (i < 20) ? (((i / 2) % 2) != 0) : 1'b0;
            tick();
            if (press_pulse[1]) begin pcnt++; if (pe < 0) pe = i; end
            if (release_pulse[1]) rcnt++;
        end
        chk("ch1_press_edge", pe, 25);
        chk("ch1_press_count", pcnt, 1);
        chk("ch1_release_count", rcnt, 0);
        buttons_raw = 4'b1111;
        repeat (10) tick();

        // Long press on ch2: held 30 edges.
        pe = -1; le = -1; lcnt = 0;
        buttons_raw = 4'b1011;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (press_pulse[2] && pe < 0) pe = i;
            if (long_pulse[2]) begin lcnt++; if (le < 0) le = i; end
        end
        chk("ch2_press_edge", pe, 5);
        chk("ch2_long_edge", le, 15);
        chk("ch2_long_count", lcnt, 1);
        buttons_raw = 4'b1111;
        repeat (12) tick();
        lcnt = 0;
        for (int i = 0; i < 20; i++) begin
            buttons_raw = (i < 8) ? 4'b1011 : 4'b1111;
            tick();
            if (long_pulse[2]) lcnt++;
        end
        chk("ch2_short_long_count", lcnt, 0);

        // ch0 and ch3 together, ch3 bounces once on edge 1.
        pe0 = -1; pe3 = -1; other = 0;
        for (int i = 0; i < 12; i++) begin
            buttons_raw = (i == 1) ? 4'b1110 : 4'b0110;
            tick();
            if (press_pulse[0] && pe0 < 0) pe0 = i;
            if (press_pulse[3] && pe3 < 0) pe3 = i;
            other += $countones(button_state[2:1]);
        end
        chk("ch0_sim_press_edge", pe0, 5);
        chk("ch3_sim_press_edge", pe3, 7);
        chk("ch12_sim_idle", other, 0);
        buttons_raw = 4'b1111;
        repeat (14) tick();

        // Reset with the ch0 counter at 2, pin kept pressed.
        buttons_raw = 4'b1110;
        repeat (4) tick();
        chk("mid_count_state", int'(button_state), 0);
        async_reset_check("mid_count_reset_outputs");
        repeat (2) tick();
        rst_n = 1'b1;
        pe = -1; pcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (press_pulse[0]) begin pcnt++; if (pe < 0) pe = i; end
        end
        chk("post_reset_press_edge", pe, 5);
        chk("post_reset_press_count", pcnt, 1);
        buttons_raw = 4'b1111;
        repeat (12) tick();

        // Randomized phase with varying flip rates and occasional async resets.
        rate = 8;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc % 250 == 0) rate = $urandom_range(2, 40);
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(0, rate - 1) == 0) buttons_raw[c] = ~buttons_raw[c];
            if ($urandom_range(0, 599) == 0) begin
                async_reset_check("rand_async_reset");
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
